// File: rtl/l1_pkg.sv
// Shared types and widths for the L1 data cache slice.
package l1_pkg;

  localparam int WORD_W      = 32;
  localparam int LINE_W      = 64;
  localparam int DEF_LADDR_W = 29;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

endpackage

// File: rtl/l1_tag_array.sv
// Valid/tag storage for the L1 data cache: one lookup port, one fill port,
// a snoop-compare invalidate port and a flash-clear input.
module l1_tag_array
  import l1_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_hit,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               snoop_en,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag,
  input  logic               flash_clr
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic             fill_match;
  logic             snoop_clr;

  assign lookup_hit = valid[lookup_index] && (tags[lookup_index] == lookup_tag);

  // A rewrite of the very line being filled also kills the fill: the L2 data may be stale.
  assign fill_match = wr_en && (wr_index == snoop_index) && (wr_tag == snoop_tag);
  assign snoop_clr  = snoop_en &&
                      ((valid[snoop_index] && (tags[snoop_index] == snoop_tag)) || fill_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (flash_clr) begin
      valid <= '0;
    end else begin
      if (wr_en)
        valid[wr_index] <= 1'b1;
      if (snoop_clr)
        valid[snoop_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      tags[wr_index] <= wr_tag;
  end

endmodule

// File: rtl/l1_data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache in front of a shared L2.
// Define L1_SNOOP_EN for precise per-line snoop invalidate; otherwise any L2 rewrite flash-invalidates.
module l1_data_cache
  import l1_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int LADDR_W = DEF_LADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               core_req,
  input  logic               core_we,
  input  logic [31:0]        core_addr,
  input  logic [WORD_W-1:0]  core_wdata,
  input  logic               core_trd_mod,
  input  logic [7:0]         core_trd_PID,
  output logic               core_ready,
  output logic               core_done,
  output logic [WORD_W-1:0]  core_rdata,
  output logic               read_request,
  output logic               write_request,
  output logic               start_end_same,
  output logic [LADDR_W-1:0] address,
  output logic               refresh_loc,
  output logic [WORD_W-1:0]  refresh_data,
  output logic               trd_mod,
  output logic [7:0]         trd_PID,
  input  logic               L2_ready,
  input  logic [LINE_W-1:0]  read_data,
  input  logic               rewrite_active,
  input  logic [LADDR_W-1:0] rewrite_address
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = LADDR_W - INDEX_W;

  state_t             state;
  logic [WORD_W-1:0]  data_lo [LINES];
  logic [WORD_W-1:0]  data_hi [LINES];
  logic [LADDR_W-1:0] req_line;
  logic [INDEX_W-1:0] req_index;
  logic               word_sel;
  logic               sel_q;
  logic               hit;
  logic               accept;
  logic               fill;
  logic               store_hit;
  logic               snoop_en;
  logic               flash_clr;
  logic               unused_bits;

  assign req_line       = core_addr[LADDR_W+2:3];
  assign req_index      = req_line[INDEX_W-1:0];
  assign word_sel       = core_addr[2];
  assign unused_bits    = ^core_addr[1:0];
  assign core_ready     = (state == IDLE);
  assign start_end_same = 1'b1;
  assign accept         = core_req && (state == IDLE);
  assign fill           = (state == RD_MISS) && L2_ready;
  assign store_hit      = accept && core_we && hit;

`ifdef L1_SNOOP_EN
  assign snoop_en  = rewrite_active;
  assign flash_clr = 1'b0;
`else
  assign snoop_en  = 1'b0;
  assign flash_clr = rewrite_active;
`endif

  l1_tag_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tags (
    .clk          (clk),
    .reset        (reset),
    .lookup_index (req_index),
    .lookup_tag   (req_line[LADDR_W-1:INDEX_W]),
    .lookup_hit   (hit),
    .wr_en        (fill),
    .wr_index     (address[INDEX_W-1:0]),
    .wr_tag       (address[LADDR_W-1:INDEX_W]),
    .snoop_en     (snoop_en),
    .snoop_index  (rewrite_address[INDEX_W-1:0]),
    .snoop_tag    (rewrite_address[LADDR_W-1:INDEX_W]),
    .flash_clr    (flash_clr)
  );

  always_ff @(posedge clk) begin
    if (fill) begin
      data_lo[address[INDEX_W-1:0]] <= read_data[WORD_W-1:0];
      data_hi[address[INDEX_W-1:0]] <= read_data[LINE_W-1:WORD_W];
    end else if (store_hit) begin
      if (word_sel)
        data_hi[req_index] <= core_wdata;
      else
        data_lo[req_index] <= core_wdata;
    end
  end

  // Request, address and data stay frozen until the L2_ready edge, then drop together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      core_done     <= 1'b0;
      core_rdata    <= '0;
      read_request  <= 1'b0;
      write_request <= 1'b0;
      address       <= '0;
      refresh_loc   <= 1'b0;
      refresh_data  <= '0;
      trd_mod       <= 1'b0;
      trd_PID       <= '0;
      sel_q         <= 1'b0;
    end else begin
      core_done <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req) begin
            if (!core_we && hit) begin
              core_done  <= 1'b1;
              core_rdata <= word_sel ? data_hi[req_index] : data_lo[req_index];
            end else begin
              address <= req_line;
              trd_mod <= core_trd_mod;
              trd_PID <= core_trd_PID;
              sel_q   <= word_sel;
              if (core_we) begin
                state         <= WR_THRU;
                write_request <= 1'b1;
                refresh_loc   <= word_sel;
                refresh_data  <= core_wdata;
              end else begin
                state        <= RD_MISS;
                read_request <= 1'b1;
              end
            end
          end
        end
        RD_MISS: begin
          if (L2_ready) begin
            state        <= IDLE;
            read_request <= 1'b0;
            address      <= '0;
            core_done    <= 1'b1;
            core_rdata   <= sel_q ? read_data[LINE_W-1:WORD_W] : read_data[WORD_W-1:0];
          end
        end
        WR_THRU: begin
          if (L2_ready) begin
            state         <= IDLE;
            write_request <= 1'b0;
            address       <= '0;
            refresh_loc   <= 1'b0;
            refresh_data  <= '0;
            core_done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed self-checking bench for l1_data_cache with a line-level cache model.
// Expectations for rewrite tests follow L1_SNOOP_EN when it is defined.
module tb_l1_data_cache;

  localparam int LINES   = 16;
  localparam int LADDR_W = 29;

  logic               clk = 1'b0;
  logic               reset;
  logic               core_req;
  logic               core_we;
  logic [31:0]        core_addr;
  logic [31:0]        core_wdata;
  logic               core_trd_mod;
  logic [7:0]         core_trd_PID;
  logic               core_ready;
  logic               core_done;
  logic [31:0]        core_rdata;
  logic               read_request;
  logic               write_request;
  logic               start_end_same;
  logic [LADDR_W-1:0] address;
  logic               refresh_loc;
  logic [31:0]        refresh_data;
  logic               trd_mod;
  logic [7:0]         trd_PID;
  logic               L2_ready;
  logic [63:0]        read_data;
  logic               rewrite_active;
  logic [LADDR_W-1:0] rewrite_address;

  always #5 clk = ~clk;

  l1_data_cache #(.LINES(LINES), .LADDR_W(LADDR_W)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_trd_mod(core_trd_mod), .core_trd_PID(core_trd_PID),
    .core_ready(core_ready), .core_done(core_done), .core_rdata(core_rdata),
    .read_request(read_request), .write_request(write_request),
    .start_end_same(start_end_same), .address(address),
    .refresh_loc(refresh_loc), .refresh_data(refresh_data),
    .trd_mod(trd_mod), .trd_PID(trd_PID),
    .L2_ready(L2_ready), .read_data(read_data),
    .rewrite_active(rewrite_active), .rewrite_address(rewrite_address)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  bit run_compare  = 1'b0;

  // Model: what each cache slot holds, keyed by full line address
  bit                 m_valid [LINES];
  logic [LADDR_W-1:0] m_line  [LINES];
  logic [31:0]        m_word  [LINES][2];

  logic               exp_ready, exp_done, exp_chk_rdata, exp_rreq, exp_wreq, exp_loc, exp_trd_mod;
  logic [31:0]        exp_rdata, exp_wdata;
  logic [LADDR_W-1:0] exp_addr;
  logic [7:0]         exp_trd_pid;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_compare) begin
      check_output("core_ready", 64'(core_ready), 64'(exp_ready));
      check_output("core_done", 64'(core_done), 64'(exp_done));
      check_output("read_request", 64'(read_request), 64'(exp_rreq));
      check_output("write_request", 64'(write_request), 64'(exp_wreq));
      check_output("start_end_same", 64'(start_end_same), 64'd1);
      if (exp_rreq || exp_wreq || !reset) begin
        check_output("address", 64'(address), 64'(exp_addr));
        check_output("trd_mod", 64'(trd_mod), 64'(exp_trd_mod));
        check_output("trd_PID", 64'(trd_PID), 64'(exp_trd_pid));
      end
      if (exp_wreq || !reset) begin
        check_output("refresh_loc", 64'(refresh_loc), 64'(exp_loc));
        check_output("refresh_data", 64'(refresh_data), 64'(exp_wdata));
      end
      if (exp_chk_rdata)
        check_output("core_rdata", 64'(core_rdata), 64'(exp_rdata));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_of(input logic [31:0] a);
    return int'(a[31:3]) % LINES;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[slot_of(a)] && (m_line[slot_of(a)] == a[31:3]);
  endfunction

  task automatic model_rewrite(input logic [LADDR_W-1:0] ra);
`ifdef L1_SNOOP_EN
    int idx;
    idx = int'(ra) % LINES;
    if (m_valid[idx] && m_line[idx] == ra)
      m_valid[idx] = 1'b0;
`else
    for (int i = 0; i < LINES; i++)
      m_valid[i] = 1'b0;
`endif
  endtask

  task automatic set_reset_expect();
    for (int i = 0; i < LINES; i++)
      m_valid[i] = 1'b0;
    exp_ready = 1; exp_done = 0; exp_rreq = 0; exp_wreq = 0; exp_addr = '0;
    exp_loc = 0; exp_wdata = '0; exp_trd_mod = 0; exp_trd_pid = '0;
    exp_rdata = '0; exp_chk_rdata = 1;
  endtask

  task automatic drive_access(input logic [31:0] a, input bit we, input logic [31:0] wd);
    core_req = 1; core_we = we; core_addr = a; core_wdata = wd;
    core_trd_mod = a[3]; core_trd_PID = a[10:3] ^ 8'h5A;
  endtask

  task automatic apply_load(input logic [31:0] a, input int l2_wait, input logic [63:0] l2_line,
                            output bit missed, output logic [LADDR_W-1:0] seen_addr,
                            output logic [31:0] got);
    int idx;
    bit w, hit;
    idx = slot_of(a); w = a[2]; hit = model_hit(a);
    drive_access(a, 1'b0, 32'h0);
    tick();
    core_req = 0;
    missed = read_request; seen_addr = address;
    if (hit) begin
      exp_done = 1; exp_rdata = m_word[idx][w]; exp_chk_rdata = 1;
    end else begin
      exp_ready = 0; exp_rreq = 1; exp_addr = a[31:3];
      exp_trd_mod = a[3]; exp_trd_pid = a[10:3] ^ 8'h5A;
      repeat (l2_wait) tick();
      L2_ready = 1; read_data = l2_line;
      tick();
      L2_ready = 0; read_data = '0;
      m_valid[idx] = 1; m_line[idx] = a[31:3];
      m_word[idx][0] = l2_line[31:0]; m_word[idx][1] = l2_line[63:32];
      exp_ready = 1; exp_rreq = 0; exp_done = 1; exp_rdata = m_word[idx][w]; exp_chk_rdata = 1;
    end
    got = core_rdata;
    tick();
    exp_done = 0; exp_chk_rdata = 0;
  endtask

  task automatic apply_store(input logic [31:0] a, input logic [31:0] wd, input int l2_wait,
                             input bit snoop_same, output bit seen_loc,
                             output logic [31:0] seen_data, output bit seen_wreq);
    drive_access(a, 1'b1, wd);
    if (snoop_same) begin
      rewrite_active = 1; rewrite_address = a[31:3];
    end
    tick();
    core_req = 0; rewrite_active = 0;
    if (model_hit(a))
      m_word[slot_of(a)][a[2]] = wd;
    if (snoop_same)
      model_rewrite(a[31:3]);
    seen_loc = refresh_loc; seen_data = refresh_data; seen_wreq = write_request;
    exp_ready = 0; exp_wreq = 1; exp_addr = a[31:3]; exp_loc = a[2]; exp_wdata = wd;
    exp_trd_mod = a[3]; exp_trd_pid = a[10:3] ^ 8'h5A;
    repeat (l2_wait) tick();
    L2_ready = 1;
    tick();
    L2_ready = 0;
    exp_ready = 1; exp_wreq = 0; exp_done = 1;
    tick();
    exp_done = 0;
  endtask

  task automatic apply_rewrite(input logic [LADDR_W-1:0] ra);
    rewrite_active = 1; rewrite_address = ra;
    tick();
    rewrite_active = 0;
    model_rewrite(ra);
  endtask

  initial begin
    bit                 missed, loc, wreq, want_miss;
    logic [LADDR_W-1:0] seen_addr;
    logic [31:0]        got, sdata, want_word;

    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    core_trd_mod = 0; core_trd_PID = '0; L2_ready = 0; read_data = '0;
    rewrite_active = 0; rewrite_address = '0;
    reset = 1;
    #2 reset = 0;
    set_reset_expect();
    run_compare = 1;
    repeat (2) tick();
    check_output("reset_core_ready", 64'(core_ready), 64'd1);
    check_output("reset_start_end_same", 64'(start_end_same), 64'd1);
    check_output("reset_core_done", 64'(core_done), 64'd0);
    reset = 1; exp_chk_rdata = 0;
    tick();

    $display("[TB] cold load 0x10");
    apply_load(32'h10, 3, 64'h1111_2222_3333_4444, missed, seen_addr, got);
    check_output("cold_load_missed", 64'(missed), 64'd1);
    check_output("cold_load_address", 64'(seen_addr), 64'h2);
    check_output("cold_load_rdata", 64'(got), 64'h3333_4444);

    apply_load(32'h14, 0, 64'h0, missed, seen_addr, got);
    check_output("reload_hit", 64'(missed), 64'd0);
    check_output("reload_rdata", 64'(got), 64'h1111_2222);

    $display("[TB] store to cached 0x14");
    apply_store(32'h14, 32'hDEAD_BEEF, 2, 1'b0, loc, sdata, wreq);
    check_output("store_write_request", 64'(wreq), 64'd1);
    check_output("store_refresh_loc", 64'(loc), 64'd1);
    check_output("store_refresh_data", 64'(sdata), 64'hDEAD_BEEF);
    apply_load(32'h14, 0, 64'h0, missed, seen_addr, got);
    check_output("load_after_store_hit", 64'(missed), 64'd0);
    check_output("load_after_store_rdata", 64'(got), 64'hDEAD_BEEF);

    $display("[TB] store to uncached 0x40");
    apply_store(32'h40, 32'hCAFE_F00D, 1, 1'b0, loc, sdata, wreq);
    check_output("nwa_refresh_loc", 64'(loc), 64'd0);
    apply_load(32'h40, 1, 64'hAAAA_0000_BBBB_1111, missed, seen_addr, got);
    check_output("nwa_load_missed", 64'(missed), 64'd1);
    check_output("nwa_load_rdata", 64'(got), 64'hBBBB_1111);

    $display("[TB] rewrite of line 0x2");
    apply_rewrite(29'h2);
    apply_load(32'h10, 0, 64'h5555_6666_7777_8888, missed, seen_addr, got);
    check_output("snoop_match_missed", 64'(missed), 64'd1);
    check_output("snoop_match_rdata", 64'(got), 64'h7777_8888);

    apply_rewrite(29'h7);
`ifdef L1_SNOOP_EN
    want_miss = 1'b0; want_word = 32'h7777_8888;
`else
    want_miss = 1'b1; want_word = 32'hBBBB_CCCC;
`endif
    apply_load(32'h10, 0, 64'h9999_AAAA_BBBB_CCCC, missed, seen_addr, got);
    check_output("snoop_other_missed", 64'(missed), 64'(want_miss));
    check_output("snoop_other_rdata", 64'(got), 64'(want_word));

    $display("[TB] store hit racing a rewrite of the same line");
    apply_store(32'h10, 32'h1234_5678, 0, 1'b1, loc, sdata, wreq);
    apply_load(32'h10, 1, 64'h0BAD_0BAD_4321_8765, missed, seen_addr, got);
    check_output("race_invalidate_missed", 64'(missed), 64'd1);
    check_output("race_invalidate_rdata", 64'(got), 64'h4321_8765);

    $display("[TB] reset during a stalled miss");
    drive_access(32'h18, 1'b0, 32'h0);
    tick();
    core_req = 0;
    exp_ready = 0; exp_rreq = 1; exp_addr = 29'h3; exp_trd_mod = 1'b1; exp_trd_pid = 8'h03 ^ 8'h5A;
    repeat (9) tick();
    reset = 0;
    #1;
    check_output("async_reset_read_request", 64'(read_request), 64'd0);
    check_output("async_reset_core_ready", 64'(core_ready), 64'd1);
    check_output("async_reset_address", 64'(address), 64'd0);
    set_reset_expect();
    repeat (2) tick();
    reset = 1; exp_chk_rdata = 0;
    tick();
    apply_load(32'h14, 0, 64'h2222_3333_4444_5555, missed, seen_addr, got);
    check_output("post_reset_missed", 64'(missed), 64'd1);
    check_output("post_reset_rdata", 64'(got), 64'h2222_3333);

    tick();
    run_compare = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/l1_data_cache.md
# l1_data_cache

- Per-core L1 data cache, direct-mapped, write-through, no write-allocate.
- Sits between one core's load/store port and that core's request slot on the shared four-core L2.
- Lines are 64 bits (two 32-bit words) to match the L2 read width.
- Keeps itself coherent by invalidating lines named on the L2 rewrite broadcast.

## Interface
Parameters:
- LINES, 16, number of lines (power of two ≥2); INDEX_W = log2(LINES)
- LADDR_W, 29, line-address width seen by L2

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- core_req  in  1  access request, accepted when core_ready=1
- core_we  in  1  1=store, 0=load
- core_addr  in  32  byte address; bits[1:0] ignored; line = [31:3], word select = [2]
- core_wdata  in  32  store data
- core_trd_mod, core_trd_PID  in  1, 8  thread-mode tag of the access
- core_ready  out  1  idle, can accept
- core_done  out  1  one-cycle completion pulse (load or store)
- core_rdata  out  32  load data, valid while core_done=1 after a load
- read_request, write_request  out  1 each  L2 request lines
- start_end_same  out  1  constant 1 (single-line accesses only)
- address  out  LADDR_W  line address to L2
- refresh_loc  out  1  word select for L2 write
- refresh_data  out  32  L2 write data
- trd_mod, trd_PID  out  1, 8  captured thread tag to L2
- L2_ready  in  1  L2 grant, this core
- read_data  in  64  L2 line; {word1, word0}
- rewrite_active  in  1  another core is writing L2
- rewrite_address  in  LADDR_W  line being written

## Operation
- Storage per line: valid bit, tag = line[LADDR_W-1:INDEX_W], two data words.
- FSM states: IDLE, RD_MISS, WR_THRU. core_ready = (state==IDLE).
- IDLE, on accepted load:
  - hit: core_done=1 and the selected word registered to core_rdata on the next cycle; FSM stays IDLE.
  - miss: capture line, word select and thread tag; go to RD_MISS.
- IDLE, on accepted store:
  - If hit, update the cached word at the accept edge.
  - In all cases capture address, data and tag; go to WR_THRU.
- RD_MISS:
  - Drive read_request=1 and the captured address.
  - On the edge where L2_ready=1: write read_data into the line, set valid, write tag.
  - Next cycle: core_done=1 with the selected word; FSM returns to IDLE.
- WR_THRU:
  - Drive write_request=1, refresh_loc = word select, refresh_data.
  - On the edge where L2_ready=1, go to IDLE; core_done=1 the following cycle.
- Snoop: when rewrite_active=1 and the line at rewrite_address[INDEX_W-1:0] is valid with matching tag, clear its valid bit.
- Snoop vs. same-cycle local store hit to the same line: the invalidate wins.
- Reset: all valid bits cleared, FSM to IDLE; all outputs 0 except core_ready=1 and start_end_same=1.
- Reset mid-transaction abandons the request; L2 tolerates the dropped request.

## Timing
- Hit load latency: 1 cycle (accept edge → core_done).
- Miss/store latency: L2 wait + 2 cycles.
- Request hold rule:
  - Request, address and data are held constant from entry into RD_MISS/WR_THRU through the cycle in which L2_ready=1.
  - They are deasserted in the cycle after; L2 must never see a re-request from this core in that cycle.
- read_data is sampled only in a cycle with L2_ready=1.
- Back-to-back: a new request may be accepted the cycle core_done pulses.

## Configuration
- L1_SNOOP_EN defined: precise per-line invalidate as above.
- L1_SNOOP_EN undefined:
  - Any rewrite_active=1 clears every valid bit (flash invalidate).
  - rewrite_address is ignored.
  - Correct but lower hit rate.

## Structure
- Package l1_pkg: FSM state enum (IDLE, RD_MISS, WR_THRU), WORD_W=32, LINE_W=64, LADDR_W default.
- Sub-module l1_tag_array: valid/tag storage.
  - One lookup port, one fill/invalidate write port.
  - Snoop-compare port.
  - Flash-clear input.

## Test plan
- Cold load 0x0000_0010: read_request high, address=0x2; L2_ready after 3 cycles with read_data=0x1111_2222_3333_4444 → core_rdata=0x3333_4444 one cycle later. Reload of 0x14 hits in 1 cycle with 0x1111_2222, no L2 request.
- Store 0xDEAD_BEEF to cached 0x14:
  - write_request=1, refresh_loc=1, refresh_data=0xDEAD_BEEF until L2_ready.
  - A later load of 0x14 hits and returns 0xDEAD_BEEF.
- Store to uncached 0x40: L2 write occurs; a later load of 0x40 misses (no allocate).
- rewrite_active=1, rewrite_address=0x2 while line 0x2 is valid → next load of 0x10 misses. Without L1_SNOOP_EN, rewrite_address=0x7 also invalidates line 0x2.
- Hold L2_ready low 20 cycles during RD_MISS: request/address stable, core_ready=0. Assert reset at cycle 10: outputs reach reset values immediately and all lines are invalid.
